// File: rtl/bcd_entry_controller.sv
// Button synchroniser/debouncer driving a 4-digit BCD entry register.
// Define AUTO_REPEAT_EN to add hold-to-repeat on increment/decrement.
module bcd_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] switch,
    input  logic [3:0] button,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       update
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          deb_q, deb_d;
    logic [3:0]          press_q, press_d;
    logic [3:0][CW-1:0]  dcnt_q, dcnt_d;
    logic [3:0][3:0]     dig_q, dig_d;
    logic [3:0][3:0]     inc_val, dec_val;
    logic [3:0]          ld_lo, ld_hi;
    logic [3:0]          cmd;
    logic                chg_q, update_q;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
        press_d = deb_d & ~deb_q;
    end

    // Ripple carry/borrow stops at the first digit that does not wrap
    always_comb begin : bcd_step
        logic carry;
        logic borrow;
        carry   = 1'b1;
        borrow  = 1'b1;
        inc_val = dig_q;
        dec_val = dig_q;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (dig_q[i] == 4'd9) begin
                    inc_val[i] = 4'd0;
                end else begin
                    inc_val[i] = dig_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
            if (borrow) begin
                if (dig_q[i] == 4'd0) begin
                    dec_val[i] = 4'd9;
                end else begin
                    dec_val[i] = dig_q[i] - 4'd1;
                    borrow     = 1'b0;
                end
            end
        end
    end

    assign ld_lo = (switch[3:0] > 4'd9) ? 4'd9 : switch[3:0];
    assign ld_hi = (switch[7:4] > 4'd9) ? 4'd9 : switch[7:4];

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rpt_q, rpt_d;
    logic [1:0]    rep_q, rep_d;
    logic          fire;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE
    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        rpt_d  = rpt_q;
        rep_d  = '0;
        fire   = rpt_q ? (rcnt_q == RW'(REPEAT_RATE - 1))
                       : (rcnt_q == RW'(REPEAT_DELAY - 1));
        if (!(deb_d[0] | deb_d[1]) || (press_d[0] | press_d[1])) begin
            rcnt_d = '0;
            rpt_d  = 1'b0;
        end else if (fire) begin
            rcnt_d   = '0;
            rpt_d    = 1'b1;
            rep_d[0] = deb_d[0];
            rep_d[1] = ~deb_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q <= '0;
            rpt_q  <= 1'b0;
            rep_q  <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rpt_q  <= rpt_d;
            rep_q  <= rep_d;
        end
    end

    assign cmd = press_q | {2'b00, rep_q};
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
    assign cmd = press_q;
`endif

    always_comb begin
        dig_d = dig_q;
        if (cmd[2]) begin
            dig_d = '0;
        end else if (cmd[3]) begin
            dig_d = {4'd0, 4'd0, ld_hi, ld_lo};
        end else if (cmd[0]) begin
            dig_d = inc_val;
        end else if (cmd[1]) begin
            dig_d = dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            dcnt_q   <= '0;
            press_q  <= '0;
            dig_q    <= '0;
            chg_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            press_q  <= press_d;
            dig_q    <= dig_d;
            chg_q    <= (dig_d != dig_q);
            update_q <= chg_q;
        end
    end

    assign digit1 = dig_q[0];
    assign digit2 = dig_q[1];
    assign digit3 = dig_q[2];
    assign digit4 = dig_q[3];
    assign update = update_q;

endmodule

// File: tb/tb_bcd_entry_controller.sv
// Bench for bcd_entry_controller: integer value model plus directed presses.
// Honours AUTO_REPEAT_EN the same way as the design.
module tb_bcd_entry_controller;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] switch = 8'h00;
    logic [3:0] button = 4'h0;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       update;

    int checks = 0;
    int errors = 0;
    int mv = 0;
    int h1 = 0;
    int h2 = 0;
    int upd_cnt = 0;
    bit chk_en = 1'b0;

    bcd_entry_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch(switch),
        .button(button),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3),
        .digit4(digit4),
        .update(update)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dig();
        return {digit4, digit3, digit2, digit1};
    endfunction

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sat(input int n);
        return (n > 9) ? 9 : n;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: one command applied to an integer 0..9999 with fixed priority
    task automatic apply(input logic [3:0] m);
        if (m[2]) mv = 0;
        else if (m[3]) mv = sat(int'(switch[7:4])) * 10 + sat(int'(switch[3:0]));
        else if (m[0]) mv = (mv + 1) % 10000;
        else if (m[1]) mv = (mv + 9999) % 10000;
    endtask

    // Digits must track the model; update must flag the previous cycle's change
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("digits", int'(dig()), int'(bcd(mv)));
            chk("update", int'(update), int'(h1 != h2));
        end
        h2 = h1;
        h1 = mv;
    end

    always @(negedge clk) if (update) upd_cnt++;

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        mv = 0;
        h1 = 0;
        h2 = 0;
        chk_en = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk) button = m;
        repeat (7) @(posedge clk);
        #1 apply(m);
        repeat (2) @(posedge clk);
        @(negedge clk) button = 4'h0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int u0;
        do_reset();
        #1;
        chk("reset_digits", int'(dig()), 0);
        chk("reset_update", int'(update), 0);

        // 1: latency of a held increment
        @(negedge clk) button = 4'h1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (e == 7) apply(4'h1);
            chk($sformatf("t1_digits_e%0d", e), int'(dig()), (e >= 7) ? 1 : 0);
            chk($sformatf("t1_update_e%0d", e), int'(update), (e == 8) ? 1 : 0);
        end
        @(negedge clk) button = 4'h0;
        repeat (8) @(posedge clk);

        // 2: glitches shorter than the debounce window
        do_reset();
        u0 = upd_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) button = 4'h1;
            repeat (3) @(negedge clk);
            button = 4'h0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("t2_digits", int'(dig()), 0);
        chk("t2_no_update", upd_cnt - u0, 0);

        // 3: carry and borrow across digits
        do_reset();
        switch = 8'h09;
        press(4'h8);
        chk("t3_load9", int'(dig()), 16'h0009);
        press(4'h1);
        chk("t3_0010", int'(dig()), 16'h0010);
        press(4'h4);
        press(4'h2);
        chk("t3_9999", int'(dig()), 16'h9999);
        press(4'h1);
        chk("t3_wrap0", int'(dig()), 16'h0000);
        switch = 8'h99;
        press(4'h8);
        for (int k = 0; k < 900; k++) press(4'h1);
        chk("t3_0999", int'(dig()), 16'h0999);
        press(4'h1);
        chk("t3_1000", int'(dig()), 16'h1000);
        press(4'h2);
        chk("t3_dec0999", int'(dig()), 16'h0999);

        // 4: saturating load, idempotent load, clear priority
        switch = 8'hC7;
        press(4'h8);
        chk("t4_load", int'(dig()), 16'h0097);
        u0 = upd_cnt;
        press(4'h8);
        chk("t4_same_load", upd_cnt - u0, 0);
        press(4'hC);
        chk("t4_clear_wins", int'(dig()), 16'h0000);
        u0 = upd_cnt;
        press(4'h4);
        chk("t4_clear_at0", upd_cnt - u0, 0);

        // 5: reset during a partial debounce
        switch = 8'h23;
        press(4'h8);
        @(negedge clk) button = 4'h1;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        mv = 0;
        h1 = 0;
        h2 = 0;
        chk("t5_reset", int'(dig()), 0);
        @(negedge clk) reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 7) apply(4'h1);
            chk($sformatf("t5_digits_e%0d", e), int'(dig()), (e >= 7) ? 1 : 0);
        end
        @(negedge clk) button = 4'h0;
        repeat (8) @(posedge clk);

        // 6: long hold of increment
        do_reset();
        @(negedge clk) button = 4'h1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
`ifdef AUTO_REPEAT_EN
            if (e == 7 || e == 27 || e == 32 || e == 37 || e == 42 || e == 47)
                apply(4'h1);
`else
            if (e == 7) apply(4'h1);
`endif
            if (e == 44) @(negedge clk) button = 4'h0;
        end
`ifdef AUTO_REPEAT_EN
        chk("t6_hold", int'(dig()), 16'h0006);
`else
        chk("t6_hold", int'(dig()), 16'h0001);
`endif
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
